// File: rtl/register_file_pkg.sv
// Uop package: register/value types shared by the pipeline, plus register-file
// constants and the init-sweep FSM state type.
package Uop;

  localparam int unsigned REG_W = 5;
  localparam int unsigned VAL_W = 32;

  typedef logic [REG_W-1:0] reg_t;
  typedef logic [VAL_W-1:0] val_t;

  localparam int unsigned NUM_REGS = 2 ** $bits(reg_t);

  typedef enum logic {
    RF_INIT,
    RF_RUN
  } rf_state_t;

  // True when a register index names the last entry of the array.
  function automatic logic is_last_reg(input reg_t idx);
    return idx == reg_t'(NUM_REGS - 1);
  endfunction

endpackage

// File: rtl/regfile_write_if.sv
// Writeback-to-register-file write channel. The register file is the Server end.
interface regfile_write_if;
  import Uop::*;

  logic en;
  reg_t addr;
  val_t val;

  modport Server (input en, addr, val);
  modport Client (output en, addr, val);

endinterface

// File: rtl/regfile_init_sweep.sv
// Post-reset clearing sequencer for the register file. Walks every register
// index once after reset, then parks in RUN until the next reset.
module regfile_init_sweep
  import Uop::*;
(
  input  logic clk,
  input  logic rst,
  output logic ready,
  output logic sweep_en,
  output reg_t sweep_idx
);

  rf_state_t state;

  // Sweep FSM: one register cleared per cycle, RUN entered on the last one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RF_INIT;
      sweep_idx <= '0;
      sweep_en  <= 1'b1;
      ready     <= 1'b0;
    end else begin
      case (state)
        RF_INIT: begin
          if (is_last_reg(sweep_idx)) begin
            state     <= RF_RUN;
            sweep_idx <= '0;
            sweep_en  <= 1'b0;
            ready     <= 1'b1;
          end else begin
            sweep_idx <= sweep_idx + reg_t'(1);
          end
        end
        RF_RUN: begin
          state <= RF_RUN;
        end
        default: begin
          state     <= RF_INIT;
          sweep_idx <= '0;
          sweep_en  <= 1'b1;
          ready     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/register_file.sv
// Architectural register file: one write port (writeback), NUM_READ_PORTS
// combinational read ports, hardware clear sweep after reset.
// Optional build macro: REGFILE_WRITE_THROUGH_EN forwards a same-cycle write
// to any read port addressing the same register.
module register_file
  import Uop::*;
#(
  parameter int unsigned NUM_READ_PORTS = 2,
  parameter int unsigned HARDWIRE_X0    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_write_if.Server        write0,
  input  reg_t                   rAddr [NUM_READ_PORTS],
  output val_t                   rVal  [NUM_READ_PORTS],
  output logic                   ready,
  output logic                   dropErr
);

  localparam bit X0_ZERO = (HARDWIRE_X0 != 0);

  val_t regs [NUM_REGS];

  logic sweep_en;
  reg_t sweep_idx;

  logic wr_ok;
  logic arr_we;
  reg_t arr_waddr;
  val_t arr_wdata;

  regfile_init_sweep u_sweep (
    .clk       (clk),
    .rst       (rst),
    .ready     (ready),
    .sweep_en  (sweep_en),
    .sweep_idx (sweep_idx)
  );

  // A write is architecturally visible only in RUN and when not aimed at a hardwired x0.
  assign wr_ok = ready && write0.en && !(X0_ZERO && (write0.addr == '0));

  // Single array write port: sweep clear has priority, otherwise the writeback port.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = write0.addr;
    arr_wdata = write0.val;
    if (sweep_en) begin
      arr_we    = 1'b1;
      arr_waddr = sweep_idx;
      arr_wdata = '0;
    end else if (wr_ok) begin
      arr_we = 1'b1;
    end
  end

  // Storage array, deliberately not reset; the sweep defines its contents.
  always_ff @(posedge clk) begin
    if (arr_we) begin
      regs[arr_waddr] <= arr_wdata;
    end
  end

  // Sticky flag for writeback attempts that arrive before the sweep finishes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dropErr <= 1'b0;
    end else if (!ready && write0.en) begin
      dropErr <= 1'b1;
    end
  end

  // Read ports: zero during the sweep and for hardwired x0, optional write forwarding.
  always_comb begin
    for (int i = 0; i < int'(NUM_READ_PORTS); i++) begin
      rVal[i] = '0;
      if (ready) begin
        if (X0_ZERO && (rAddr[i] == '0)) begin
          rVal[i] = '0;
`ifdef REGFILE_WRITE_THROUGH_EN
        end else if (wr_ok && (write0.addr == rAddr[i])) begin
          rVal[i] = write0.val;
`endif
        end else begin
          rVal[i] = regs[rAddr[i]];
        end
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: two instances (x0 hardwired / ordinary)
// share the stimulus and are compared against a behavioural register model.
module tb_register_file;
  import Uop::*;

  localparam int NP = 2;
  localparam int NR = 32;

  logic clk;
  logic rst_n;
  reg_t raddr [NP];
  val_t rval1 [NP];
  val_t rval0 [NP];
  logic ready1, ready0, drop1, drop0;

  regfile_write_if wif();

  register_file #(.NUM_READ_PORTS(NP), .HARDWIRE_X0(1)) dut_x0 (
    .clk(clk), .rst(rst_n), .write0(wif), .rAddr(raddr),
    .rVal(rval1), .ready(ready1), .dropErr(drop1)
  );

  register_file #(.NUM_READ_PORTS(NP), .HARDWIRE_X0(0)) dut_plain (
    .clk(clk), .rst(rst_n), .write0(wif), .rAddr(raddr),
    .rVal(rval0), .ready(ready0), .dropErr(drop0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Behavioural model state
  val_t m_mem1 [NR];
  val_t m_mem0 [NR];
  bit   m_ready;
  bit   m_drop;
  int   m_cnt;

  function automatic val_t exp_rd(input bit x0, input reg_t a);
    if (!m_ready) return '0;
    if (x0 && a == 0) return '0;
`ifdef REGFILE_WRITE_THROUGH_EN
    if (wif.en && wif.addr == a) return wif.val;
`endif
    return x0 ? m_mem1[a] : m_mem0[a];
  endfunction

  // Advance model for the coming edge, then pass the edge.
  task automatic step();
    if (!m_ready) begin
      if (wif.en) m_drop = 1'b1;
      m_cnt++;
      if (m_cnt == NR) begin
        m_ready = 1'b1;
        for (int i = 0; i < NR; i++) begin
          m_mem1[i] = '0;
          m_mem0[i] = '0;
        end
      end
    end else if (wif.en) begin
      if (wif.addr != 0) m_mem1[wif.addr] = wif.val;
      m_mem0[wif.addr] = wif.val;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    m_ready = 1'b0;
    m_drop = 1'b0;
    m_cnt = 0;
    #2;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    wif.en = 1'b0; wif.addr = '0; wif.val = '0;
    raddr[0] = reg_t'(5); raddr[1] = '0;
    assert_reset();
    checks++;
    if (ready1 !== 1'b0 || drop1 !== 1'b0) begin
      fails++; $display("FAIL reset_flags ready=%b drop=%b expected 0/0", ready1, drop1);
    end
    release_reset();
    for (int k = 1; k <= NR; k++) begin
      step();
      #1;
      checks++;
      if (ready1 !== (k >= NR) || ready0 !== (k >= NR)) begin
        fails++; $display("FAIL reset_ready cyc=%0d got=%b/%b exp=%b", k, ready1, ready0, (k >= NR));
      end
      checks++;
      if (rval1[0] !== 32'h0 || rval0[0] !== 32'h0) begin
        fails++; $display("FAIL reset_rval cyc=%0d got=%h/%h exp=0", k, rval1[0], rval0[0]);
      end
    end
  endtask

  task automatic test_write_read();
    wif.en = 1'b1; wif.addr = reg_t'(7); wif.val = 32'hDEAD_BEEF;
    step();
    wif.en = 1'b0;
    raddr[0] = reg_t'(7); raddr[1] = reg_t'(7);
    #1;
    for (int p = 0; p < NP; p++) begin
      checks++;
      if (rval1[p] !== 32'hDEAD_BEEF || rval0[p] !== 32'hDEAD_BEEF) begin
        fails++; $display("FAIL write_read port=%0d got=%h/%h exp=deadbeef", p, rval1[p], rval0[p]);
      end
    end
  endtask

  task automatic test_x0();
    wif.en = 1'b1; wif.addr = '0; wif.val = 32'h1234;
    step();
    raddr[0] = '0; raddr[1] = '0;
    wif.val = 32'h5678;
    #1;
    checks++;
    if (rval1[0] !== 32'h0 || rval1[1] !== 32'h0) begin
      fails++; $display("FAIL x0_same_cycle got=%h/%h exp=0", rval1[0], rval1[1]);
    end
    step();
    wif.en = 1'b0;
    #1;
    for (int p = 0; p < NP; p++) begin
      checks++;
      if (rval1[p] !== 32'h0) begin
        fails++; $display("FAIL x0_hardwired port=%0d got=%h exp=0", p, rval1[p]);
      end
      checks++;
      if (rval0[p] !== 32'h5678) begin
        fails++; $display("FAIL x0_plain port=%0d got=%h exp=5678", p, rval0[p]);
      end
    end
  endtask

  task automatic test_write_through();
    val_t exp;
    wif.en = 1'b1; wif.addr = reg_t'(3); wif.val = 32'h1111;
    step();
    wif.val = 32'hA5A5;
    raddr[0] = reg_t'(3); raddr[1] = reg_t'(4);
    #1;
`ifdef REGFILE_WRITE_THROUGH_EN
    exp = 32'hA5A5;
`else
    exp = 32'h1111;
`endif
    checks++;
    if (rval1[0] !== exp || rval0[0] !== exp) begin
      fails++; $display("FAIL wt_same_cycle got=%h/%h exp=%h", rval1[0], rval0[0], exp);
    end
    step();
    wif.en = 1'b0;
    #1;
    checks++;
    if (rval1[0] !== 32'hA5A5 || rval0[0] !== 32'hA5A5) begin
      fails++; $display("FAIL wt_next_cycle got=%h/%h exp=a5a5", rval1[0], rval0[0]);
    end
  endtask

  task automatic test_random(input int n);
    for (int c = 0; c < n; c++) begin
      wif.en = 1'($urandom_range(0, 1));
      wif.addr = reg_t'($urandom_range(0, NR - 1));
      wif.val = val_t'($urandom);
      for (int p = 0; p < NP; p++) raddr[p] = reg_t'($urandom_range(0, NR - 1));
      if (c % 7 == 0) raddr[1] = raddr[0];
      #1;
      for (int p = 0; p < NP; p++) begin
        checks++;
        if (rval1[p] !== exp_rd(1'b1, raddr[p])) begin
          fails++; $display("FAIL rand_x0 c=%0d port=%0d a=%0d got=%h exp=%h", c, p, raddr[p], rval1[p], exp_rd(1'b1, raddr[p]));
        end
        checks++;
        if (rval0[p] !== exp_rd(1'b0, raddr[p])) begin
          fails++; $display("FAIL rand_plain c=%0d port=%0d a=%0d got=%h exp=%h", c, p, raddr[p], rval0[p], exp_rd(1'b0, raddr[p]));
        end
      end
      checks++;
      if (ready1 !== m_ready || drop1 !== m_drop) begin
        fails++; $display("FAIL rand_flags c=%0d got=%b/%b exp=%b/%b", c, ready1, drop1, m_ready, m_drop);
      end
      step();
    end
    wif.en = 1'b0;
  endtask

  task automatic verify_cleared(input string tag);
    for (int a = 0; a < NR; a++) begin
      raddr[0] = reg_t'(a);
      raddr[1] = reg_t'(NR - 1 - a);
      #1;
      checks++;
      if (rval1[0] !== 32'h0 || rval0[0] !== 32'h0 || rval1[1] !== 32'h0 || rval0[1] !== 32'h0) begin
        fails++; $display("FAIL %s a=%0d got=%h/%h/%h/%h exp=0", tag, a, rval1[0], rval0[0], rval1[1], rval0[1]);
      end
    end
  endtask

  task automatic test_drop_during_sweep();
    wif.en = 1'b0;
    assert_reset();
    release_reset();
    for (int k = 1; k <= 9; k++) step();
    wif.en = 1'b1; wif.addr = reg_t'(2); wif.val = val_t'($urandom) | 32'h1;
    step();
    wif.en = 1'b0;
    #1;
    checks++;
    if (drop1 !== 1'b1 || drop0 !== 1'b1) begin
      fails++; $display("FAIL drop_set got=%b/%b exp=1", drop1, drop0);
    end
    for (int k = 11; k <= NR; k++) step();
    #1;
    checks++;
    if (drop1 !== 1'b1 || ready1 !== 1'b1) begin
      fails++; $display("FAIL drop_sticky got drop=%b ready=%b exp=1/1", drop1, ready1);
    end
    raddr[0] = reg_t'(2); raddr[1] = reg_t'(2);
    #1;
    checks++;
    if (rval1[0] !== 32'h0 || rval0[1] !== 32'h0) begin
      fails++; $display("FAIL drop_target got=%h/%h exp=0", rval1[0], rval0[1]);
    end
  endtask

  task automatic test_reset_mid_sweep();
    assert_reset();
    release_reset();
    for (int k = 1; k <= 5; k++) step();
    wif.en = 1'b1; wif.addr = reg_t'(1); wif.val = 32'hFFFF;
    step();
    wif.en = 1'b0;
    for (int k = 7; k <= 15; k++) step();
    assert_reset();
    checks++;
    if (ready1 !== 1'b0 || drop1 !== 1'b0 || ready0 !== 1'b0 || drop0 !== 1'b0) begin
      fails++; $display("FAIL midsweep_reset got ready=%b drop=%b exp=0/0", ready1, drop1);
    end
    release_reset();
    for (int k = 1; k <= NR; k++) begin
      step();
      #1;
      checks++;
      if (ready1 !== (k >= NR)) begin
        fails++; $display("FAIL midsweep_ready cyc=%0d got=%b exp=%b", k, ready1, (k >= NR));
      end
    end
    verify_cleared("midsweep_clear");
  endtask

  task automatic test_reset_in_run();
    test_random(60);
    assert_reset();
    checks++;
    if (ready1 !== 1'b0 || drop1 !== 1'b0) begin
      fails++; $display("FAIL run_reset got ready=%b drop=%b exp=0/0", ready1, drop1);
    end
    release_reset();
    for (int k = 1; k <= NR; k++) step();
    #1;
    checks++;
    if (ready1 !== 1'b1 || ready0 !== 1'b1) begin
      fails++; $display("FAIL run_reset_ready got=%b/%b exp=1", ready1, ready0);
    end
    verify_cleared("run_reset_clear");
  endtask

  initial begin
    rst_n = 1'b0;
    wif.en = 1'b0; wif.addr = '0; wif.val = '0;
    raddr[0] = '0; raddr[1] = '0;
    test_reset();
    test_write_read();
    test_x0();
    test_write_through();
    test_random(200);
    test_drop_during_sweep();
    test_random(40);
    test_reset_mid_sweep();
    test_reset_in_run();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
